decode_ctrl_stage: RTL
======================

// Module: decode_ctrl_stage
// PURPOSE
//  Registered successor to the combinational decoder: decodes RV32I (optionally M) instructions into the ID/EX control register.
//  Generates immediates, detects load-use hazards and inserts bubbles, and honours downstream stall and branch flush.
//  Sits between the IF/ID register and the execute stage; its outputs are the ID/EX pipeline register.
// PARAMETERS
//  XLEN        32            datapath / PC / immediate width (>=32; immediates sign-extended to XLEN)
//  ALU_W       5             ALU control code width (>=5 required for full code map)
//  CNT_W       16            width of saturating illegal-instruction counter
// PORTS
//  clk          in   1        rising-edge clock
//  reset_n      in   1        asynchronous, active-low reset
//  if_valid     in   1        IF/ID holds a valid instruction
//  if_instr     in   32       instruction word
//  if_pc        in   XLEN     PC of if_instr
//  id_ready     out  1        comb: instruction accepted this cycle (handshake if_valid&id_ready)
//  ex_stall     in   1        execute stage cannot accept; hold ID/EX register
//  flush        in   1        branch/jump taken in EX; squash ID and ID/EX contents
//  ex_valid     out  1        ID/EX holds a real instruction (0 = bubble)
//  ex_alu_ctrl  out  ALU_W    ALU op code (map below)
//  ex_alu_src   out  1        1 = operand B is immediate
//  ex_mem_wen   out  1        store
//  ex_wb_sel    out  1        1 = writeback from memory (loads)
//  ex_reg_wb    out  1        register file write enable
//  ex_branch    out  1        conditional branch
//  ex_jump      out  2        00 none, 01 JAL, 10 JALR
//  ex_auipc     out  1        operand A is PC
//  ex_funct3    out  3        funct3 passthrough (load/store size/sign)
//  ex_imm       out  XLEN     decoded immediate (I/S/B/U/J by opcode; 0 for R)
//  ex_pc        out  XLEN     PC of instruction
//  ex_rs1/rs2/rd out 5 each   register indices (rd forced 0 when reg_wb=0)
//  illegal      out  1        one-cycle pulse: illegal instruction captured
//  ill_count    out  CNT_W    saturating count of illegal instructions
// BEHAVIOUR
//  - Reset (async, reset_n=0): all ex_* outputs 0, illegal=0, ill_count=0; state RUN. No capture until reset_n released.
//  - ALU codes: ADD 00 SUB 01 XOR 02 OR 03 AND 04 SLL 05 SRL 06 BEQ 07 BNE 08 SLT 09 SRA 0A AUIPC 0B BLT 0C BGE 0D
//    SLTU 0E BLTU 0F BGEU 10 PASSB(LUI) 11. SRAI selected by instr[30]; loads/stores/JAL/JALR use ADD.
//  - Hazard: haz = ex_valid & ex_wb_sel & ex_rd!=0 & (ex_rd==rs1 used | ex_rd==rs2 used); rs2 used only for R/S/B.
//  - Priority each cycle: flush > ex_stall > haz > capture.
//    flush: ex_valid<=0 next edge, id_ready=1 (current IF word discarded), other ex_* don't-care.
//    ex_stall (no flush): all ID/EX regs hold, id_ready=0.
//    haz: ex_valid<=0 (bubble), id_ready=0, state RUN->BUBBLE; BUBBLE->RUN next edge; instruction re-decoded then.
//    capture: if_valid=1 -> ID/EX loads decode, ex_valid<=1; if_valid=0 -> ex_valid<=0. Latency 1 cycle.
//  - Illegal (unknown opcode/funct3/funct7): captured as ex_valid=1 with reg_wb=mem_wen=branch=jump=0; illegal pulses
//    1 cycle; ill_count+1, saturates at all-ones. Flushed/stalled illegal words not counted.
//  - flush while in BUBBLE: state->RUN, bubble stands. reset mid-stall/bubble: immediate return to reset values.
//  - x0 destination: reg_wb may be 1, ex_rd=0; never triggers hazard.
// CONFIGURATION
//  M_EXT_EN defined: opcode 0110011 with funct7=0000001 decodes MUL..REMU to codes 12..19 (funct3 order), reg_wb=1.
//  M_EXT_EN undefined: those encodings are illegal (pulse + count), no ALU code emitted.
// TESTING
//  1 ADDI x1,x0,5 (0x00500093) valid -> next edge ex_valid=1, alu=00, alu_src=1, imm=5, rd=1, reg_wb=1.
//  2 LW x2,0(x1) then ADD x3,x2,x2 back-to-back -> one bubble (ex_valid=0, id_ready=0 1 cycle), ADD captured after.
//  3 ex_stall=1 for 3 cycles with SW in ID/EX -> ex_* constant, id_ready=0; released -> next instr captured.
//  4 flush=1 together with ex_stall=1 and haz -> ex_valid=0 next edge, id_ready=1, ill_count unchanged.
//  5 0xFFFFFFFF x3 -> illegal pulses 3 times, ill_count=3; with CNT_W=2 x5 -> saturates at 3.
//  6 MUL x5,x6,x7 (0x027302B3): M_EXT_EN -> alu=12, reg_wb=1; undefined -> illegal=1, reg_wb=0.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// RV32I decoder registered into the ID/EX pipeline register, with load-use bubble insertion.
// Optional feature macro M_EXT_EN: decode the RV32M multiply/divide group (illegal when undefined).
module decode_ctrl_stage #(
    parameter int XLEN  = 32,
    parameter int ALU_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [ALU_W-1:0] ex_alu_ctrl,
    output logic             ex_alu_src,
    output logic             ex_mem_wen,
    output logic             ex_wb_sel,
    output logic             ex_reg_wb,
    output logic             ex_branch,
    output logic [1:0]       ex_jump,
    output logic             ex_auipc,
    output logic [2:0]       ex_funct3,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] ill_count
);

    typedef enum logic [0:0] {ST_RUN, ST_BUBBLE} state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(5'h00);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(5'h01);
    localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(5'h02);
    localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(5'h03);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(5'h04);
    localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(5'h05);
    localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(5'h06);
    localparam logic [ALU_W-1:0] ALU_BEQ   = ALU_W'(5'h07);
    localparam logic [ALU_W-1:0] ALU_BNE   = ALU_W'(5'h08);
    localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(5'h09);
    localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(5'h0A);
    localparam logic [ALU_W-1:0] ALU_AUIPC = ALU_W'(5'h0B);
    localparam logic [ALU_W-1:0] ALU_BLT   = ALU_W'(5'h0C);
    localparam logic [ALU_W-1:0] ALU_BGE   = ALU_W'(5'h0D);
    localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(5'h0E);
    localparam logic [ALU_W-1:0] ALU_BLTU  = ALU_W'(5'h0F);
    localparam logic [ALU_W-1:0] ALU_BGEU  = ALU_W'(5'h10);
    localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(5'h11);
`ifdef M_EXT_EN
    localparam logic [ALU_W-1:0] ALU_MUL   = ALU_W'(5'h12);
`endif

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f, rs1_f, rs2_f;

    assign opcode = if_instr[6:0];
    assign rd_f   = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1_f  = if_instr[19:15];
    assign rs2_f  = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-11){if_instr[31]}}, if_instr[30:20]};
    assign imm_s = {{(XLEN-11){if_instr[31]}}, if_instr[30:25], if_instr[11:7]};
    assign imm_b = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){if_instr[31]}}, if_instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

    logic [ALU_W-1:0] alu_d;
    logic             alu_src_d, mem_wen_d, wb_sel_d, reg_wb_d, branch_d, auipc_d, illegal_d;
    logic [1:0]       jump_d;
    logic [XLEN-1:0]  imm_d;
    logic             rs1_used, rs2_used;

    always_comb begin
        alu_d     = ALU_ADD;
        alu_src_d = 1'b0;
        mem_wen_d = 1'b0;
        wb_sel_d  = 1'b0;
        reg_wb_d  = 1'b0;
        branch_d  = 1'b0;
        jump_d    = 2'b00;
        auipc_d   = 1'b0;
        imm_d     = '0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        illegal_d = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_d = ALU_PASSB; alu_src_d = 1'b1; reg_wb_d = 1'b1; imm_d = imm_u;
            end
            OPC_AUIPC: begin
                alu_d = ALU_AUIPC; alu_src_d = 1'b1; auipc_d = 1'b1; reg_wb_d = 1'b1; imm_d = imm_u;
            end
            OPC_JAL: begin
                jump_d = 2'b01; reg_wb_d = 1'b1; imm_d = imm_j;
            end
            OPC_JALR: begin
                jump_d = 2'b10; alu_src_d = 1'b1; reg_wb_d = 1'b1; imm_d = imm_i; rs1_used = 1'b1;
                illegal_d = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                branch_d = 1'b1; imm_d = imm_b; rs1_used = 1'b1; rs2_used = 1'b1;
                case (funct3)
                    3'b000:  alu_d = ALU_BEQ;
                    3'b001:  alu_d = ALU_BNE;
                    3'b100:  alu_d = ALU_BLT;
                    3'b101:  alu_d = ALU_BGE;
                    3'b110:  alu_d = ALU_BLTU;
                    3'b111:  alu_d = ALU_BGEU;
                    default: illegal_d = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                alu_src_d = 1'b1; wb_sel_d = 1'b1; reg_wb_d = 1'b1; imm_d = imm_i; rs1_used = 1'b1;
                illegal_d = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                mem_wen_d = 1'b1; alu_src_d = 1'b1; imm_d = imm_s; rs1_used = 1'b1; rs2_used = 1'b1;
                illegal_d = (funct3 > 3'b010);
            end
            OPC_IMM: begin
                alu_src_d = 1'b1; reg_wb_d = 1'b1; imm_d = imm_i; rs1_used = 1'b1;
                case (funct3)
                    3'b000: alu_d = ALU_ADD;
                    3'b001: begin alu_d = ALU_SLL; illegal_d = (funct7 != F7_BASE); end
                    3'b010: alu_d = ALU_SLT;
                    3'b011: alu_d = ALU_SLTU;
                    3'b100: alu_d = ALU_XOR;
                    3'b101: begin
                        // shift-type selected by instr[30]; the rest of funct7 must be zero
                        alu_d     = if_instr[30] ? ALU_SRA : ALU_SRL;
                        illegal_d = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                    3'b110: alu_d = ALU_OR;
                    default: alu_d = ALU_AND;
                endcase
            end
            OPC_OP: begin
                reg_wb_d = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  alu_d = ALU_ADD;
                        3'b001:  alu_d = ALU_SLL;
                        3'b010:  alu_d = ALU_SLT;
                        3'b011:  alu_d = ALU_SLTU;
                        3'b100:  alu_d = ALU_XOR;
                        3'b101:  alu_d = ALU_SRL;
                        3'b110:  alu_d = ALU_OR;
                        default: alu_d = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    alu_d = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    alu_d = ALU_SRA;
                end else if (funct7 == F7_MULDIV) begin
`ifdef M_EXT_EN
                    alu_d = ALU_MUL + ALU_W'(funct3);
`else
                    illegal_d = 1'b1;
`endif
                end else begin
                    illegal_d = 1'b1;
                end
            end
            default: illegal_d = 1'b1;
        endcase
        // an illegal word travels down the pipe as a harmless no-op
        if (illegal_d) begin
            alu_d     = ALU_ADD;
            alu_src_d = 1'b0;
            mem_wen_d = 1'b0;
            wb_sel_d  = 1'b0;
            reg_wb_d  = 1'b0;
            branch_d  = 1'b0;
            jump_d    = 2'b00;
            auipc_d   = 1'b0;
            imm_d     = '0;
            rs1_used  = 1'b0;
            rs2_used  = 1'b0;
        end
    end

    state_e           state_q;
    logic             ex_valid_q, ex_alu_src_q, ex_mem_wen_q, ex_wb_sel_q, ex_reg_wb_q;
    logic             ex_branch_q, ex_auipc_q, illegal_q;
    logic [ALU_W-1:0] ex_alu_ctrl_q;
    logic [1:0]       ex_jump_q;
    logic [2:0]       ex_funct3_q;
    logic [XLEN-1:0]  ex_imm_q, ex_pc_q;
    logic [4:0]       ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [CNT_W-1:0] ill_count_q;
    logic             haz;

    // load-use: the word in ID reads the register a load in ID/EX is about to produce
    assign haz = if_valid && (state_q == ST_RUN) && ex_valid_q && ex_wb_sel_q && (ex_rd_q != 5'd0) &&
                 ((rs1_used && (rs1_f == ex_rd_q)) || (rs2_used && (rs2_f == ex_rd_q)));

    assign id_ready = flush || (!ex_stall && !haz);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            ex_valid_q    <= 1'b0;
            ex_alu_ctrl_q <= '0;
            ex_alu_src_q  <= 1'b0;
            ex_mem_wen_q  <= 1'b0;
            ex_wb_sel_q   <= 1'b0;
            ex_reg_wb_q   <= 1'b0;
            ex_branch_q   <= 1'b0;
            ex_jump_q     <= 2'b00;
            ex_auipc_q    <= 1'b0;
            ex_funct3_q   <= 3'b000;
            ex_imm_q      <= '0;
            ex_pc_q       <= '0;
            ex_rs1_q      <= 5'd0;
            ex_rs2_q      <= 5'd0;
            ex_rd_q       <= 5'd0;
            illegal_q     <= 1'b0;
            ill_count_q   <= '0;
        end else begin
            illegal_q <= 1'b0;
            if (flush) begin
                ex_valid_q <= 1'b0;
                state_q    <= ST_RUN;
            end else if (ex_stall) begin
                state_q <= state_q;
            end else if (haz) begin
                ex_valid_q <= 1'b0;
                state_q    <= ST_BUBBLE;
            end else begin
                state_q    <= ST_RUN;
                ex_valid_q <= if_valid;
                if (if_valid) begin
                    ex_alu_ctrl_q <= alu_d;
                    ex_alu_src_q  <= alu_src_d;
                    ex_mem_wen_q  <= mem_wen_d;
                    ex_wb_sel_q   <= wb_sel_d;
                    ex_reg_wb_q   <= reg_wb_d;
                    ex_branch_q   <= branch_d;
                    ex_jump_q     <= jump_d;
                    ex_auipc_q    <= auipc_d;
                    ex_funct3_q   <= funct3;
                    ex_imm_q      <= imm_d;
                    ex_pc_q       <= if_pc;
                    ex_rs1_q      <= rs1_used ? rs1_f : 5'd0;
                    ex_rs2_q      <= rs2_used ? rs2_f : 5'd0;
                    ex_rd_q       <= reg_wb_d ? rd_f : 5'd0;
                    illegal_q     <= illegal_d;
                    if (illegal_d && (ill_count_q != {CNT_W{1'b1}}))
                        ill_count_q <= ill_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_alu_ctrl = ex_alu_ctrl_q;
    assign ex_alu_src  = ex_alu_src_q;
    assign ex_mem_wen  = ex_mem_wen_q;
    assign ex_wb_sel   = ex_wb_sel_q;
    assign ex_reg_wb   = ex_reg_wb_q;
    assign ex_branch   = ex_branch_q;
    assign ex_jump     = ex_jump_q;
    assign ex_auipc    = ex_auipc_q;
    assign ex_funct3   = ex_funct3_q;
    assign ex_imm      = ex_imm_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign illegal     = illegal_q;
    assign ill_count   = ill_count_q;

endmodule
